// File: rtl/seq_pattern_tx.sv
// seq_pattern_tx: serializes a shadowed bit pattern MSB-first onto x,
// with repeat count, zero-filled inter-frame gap, done/err pulses and abort.
module seq_pattern_tx #(
    parameter int unsigned MAX_LEN = 16,
    parameter int unsigned LEN_W   = 5,
    parameter int unsigned REP_W   = 8,
    parameter int unsigned GAP_W   = 4
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               start,
    input  logic               abort,
    input  logic [MAX_LEN-1:0] pattern,
    input  logic [LEN_W-1:0]   len,
    input  logic [REP_W-1:0]   rep,
    input  logic [GAP_W-1:0]   gap,
    output logic               x,
    output logic               x_valid,
    output logic               frame_start,
    output logic               busy,
    output logic               done,
    output logic               err
);

    localparam int unsigned IDX_W = (MAX_LEN > 1) ? $clog2(MAX_LEN) : 1;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_SEND = 2'd1,
        S_GAP  = 2'd2
    } state_t;

    state_t               r_state;
    state_t               w_state_nxt;

    logic [LEN_W-1:0]     r_idx;
    logic [LEN_W-1:0]     w_idx_nxt;
    logic [REP_W-1:0]     r_frames;
    logic [REP_W-1:0]     w_frames_nxt;
    logic [GAP_W-1:0]     r_gap_cnt;
    logic [GAP_W-1:0]     w_gap_cnt_nxt;

    logic [MAX_LEN-1:0]   r_pat;
    logic [LEN_W-1:0]     r_len;
    logic [GAP_W-1:0]     r_gap;

    logic                 r_x;
    logic                 r_x_valid;
    logic                 r_frame_start;
    logic                 r_busy;
    logic                 r_done;
    logic                 r_err;

    logic                 w_x_nxt;
    logic                 w_x_valid_nxt;
    logic                 w_frame_start_nxt;
    logic                 w_busy_nxt;
    logic                 w_done_nxt;
    logic                 w_err_nxt;
    logic                 w_accept;

    logic                 w_len_ok;
    logic [LEN_W-1:0]     w_len_m1;
    logic [LEN_W-1:0]     w_rlen_m1;
    logic [LEN_W-1:0]     w_idx_m1;

    assign w_len_ok  = (len != '0) && (32'(len) <= MAX_LEN);
    assign w_len_m1  = len - LEN_W'(1);
    assign w_rlen_m1 = r_len - LEN_W'(1);
    assign w_idx_m1  = r_idx - LEN_W'(1);

    // State and registered outputs; reset clears everything immediately.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state       <= S_IDLE;
            r_idx         <= '0;
            r_frames      <= '0;
            r_gap_cnt     <= '0;
            r_x           <= 1'b0;
            r_x_valid     <= 1'b0;
            r_frame_start <= 1'b0;
            r_busy        <= 1'b0;
            r_done        <= 1'b0;
            r_err         <= 1'b0;
        end else begin
            r_state       <= w_state_nxt;
            r_idx         <= w_idx_nxt;
            r_frames      <= w_frames_nxt;
            r_gap_cnt     <= w_gap_cnt_nxt;
            r_x           <= w_x_nxt;
            r_x_valid     <= w_x_valid_nxt;
            r_frame_start <= w_frame_start_nxt;
            r_busy        <= w_busy_nxt;
            r_done        <= w_done_nxt;
            r_err         <= w_err_nxt;
        end
    end

    // Shadow copies of the transfer parameters, captured on an accepted start.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_pat <= '0;
            r_len <= '0;
            r_gap <= '0;
        end else if (w_accept) begin
            r_pat <= pattern;
            r_len <= len;
            r_gap <= gap;
        end
    end

    // Next state and next outputs; outputs default to an idle line.
    always_comb begin
        w_state_nxt       = r_state;
        w_idx_nxt         = r_idx;
        w_frames_nxt      = r_frames;
        w_gap_cnt_nxt     = r_gap_cnt;
        w_x_nxt           = 1'b0;
        w_x_valid_nxt     = 1'b0;
        w_frame_start_nxt = 1'b0;
        w_busy_nxt        = 1'b0;
        w_done_nxt        = 1'b0;
        w_err_nxt         = 1'b0;
        w_accept          = 1'b0;

        case (r_state)
            S_IDLE: begin
                if (start && !abort) begin
                    if (w_len_ok) begin
                        w_accept          = 1'b1;
                        w_state_nxt       = S_SEND;
                        w_idx_nxt         = w_len_m1;
                        w_frames_nxt      = (rep == '0) ? REP_W'(1) : rep;
                        w_x_nxt           = pattern[IDX_W'(w_len_m1)];
                        w_x_valid_nxt     = 1'b1;
                        w_frame_start_nxt = 1'b1;
                        w_busy_nxt        = 1'b1;
                    end else begin
                        w_err_nxt = 1'b1;
                    end
                end
            end

            S_SEND: begin
                if (abort) begin
                    w_state_nxt = S_IDLE;
                end else if (r_idx != '0) begin
                    w_idx_nxt     = w_idx_m1;
                    w_x_nxt       = r_pat[IDX_W'(w_idx_m1)];
                    w_x_valid_nxt = 1'b1;
                    w_busy_nxt    = 1'b1;
                end else if (r_frames > REP_W'(1)) begin
                    w_frames_nxt = r_frames - REP_W'(1);
                    if (r_gap != '0) begin
                        w_state_nxt   = S_GAP;
                        w_gap_cnt_nxt = r_gap - GAP_W'(1);
                        w_x_valid_nxt = 1'b1;
                        w_busy_nxt    = 1'b1;
                    end else begin
                        w_idx_nxt         = w_rlen_m1;
                        w_x_nxt           = r_pat[IDX_W'(w_rlen_m1)];
                        w_x_valid_nxt     = 1'b1;
                        w_frame_start_nxt = 1'b1;
                        w_busy_nxt        = 1'b1;
                    end
                end else begin
                    w_state_nxt  = S_IDLE;
                    w_frames_nxt = '0;
                    w_done_nxt   = 1'b1;
                end
            end

            S_GAP: begin
                if (abort) begin
                    w_state_nxt = S_IDLE;
                end else if (r_gap_cnt != '0) begin
                    w_gap_cnt_nxt = r_gap_cnt - GAP_W'(1);
                    w_x_valid_nxt = 1'b1;
                    w_busy_nxt    = 1'b1;
                end else begin
                    w_state_nxt       = S_SEND;
                    w_idx_nxt         = w_rlen_m1;
                    w_x_nxt           = r_pat[IDX_W'(w_rlen_m1)];
                    w_x_valid_nxt     = 1'b1;
                    w_frame_start_nxt = 1'b1;
                    w_busy_nxt        = 1'b1;
                end
            end

            default: begin
                w_state_nxt = S_IDLE;
            end
        endcase
    end

    assign x           = r_x;
    assign x_valid     = r_x_valid;
    assign frame_start = r_frame_start;
    assign busy        = r_busy;
    assign done        = r_done;
    assign err         = r_err;

endmodule

// File: tb/tb_seq_pattern_tx.sv
// Bench for seq_pattern_tx: directed scenarios plus random traffic, all checked
// against a queue-based model that expands each accepted request into its bit stream.
module tb_seq_pattern_tx;

    localparam int unsigned MAX_LEN = 16;
    localparam int unsigned LEN_W   = 5;
    localparam int unsigned REP_W   = 8;
    localparam int unsigned GAP_W   = 4;

    logic               clk = 1'b0;
    logic               reset;
    logic               start;
    logic               abort;
    logic [MAX_LEN-1:0] pattern;
    logic [LEN_W-1:0]   len;
    logic [REP_W-1:0]   rep;
    logic [GAP_W-1:0]   gap;
    logic               x;
    logic               x_valid;
    logic               frame_start;
    logic               busy;
    logic               done;
    logic               err;

    seq_pattern_tx #(
        .MAX_LEN(MAX_LEN), .LEN_W(LEN_W), .REP_W(REP_W), .GAP_W(GAP_W)
    ) u_dut (
        .clk(clk), .reset(reset), .start(start), .abort(abort),
        .pattern(pattern), .len(len), .rep(rep), .gap(gap),
        .x(x), .x_valid(x_valid), .frame_start(frame_start),
        .busy(busy), .done(done), .err(err)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic x;
        logic v;
        logic fs;
        logic busy;
        logic done;
        logic err;
    } exp_t;

    exp_t q[$];
    exp_t cur;

    int total = 0;
    int bad   = 0;

    // Capture of the current scenario: stream, frame_start positions, detector hits.
    logic [31:0] xs;
    int          xs_n;
    int          cyc;
    logic [31:0] fs_mask;
    logic [31:0] z_mask;
    int          z_cnt;
    logic [3:0]  det_h;
    int          det_n;
    int          done_cyc;

    task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        total++;
        if (obs !== expv) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, obs, expv, $time);
        end
    endtask

    task automatic check_outs();
        check_val("x",           32'(x),           32'(cur.x));
        check_val("x_valid",     32'(x_valid),     32'(cur.v));
        check_val("frame_start", 32'(frame_start), 32'(cur.fs));
        check_val("busy",        32'(busy),        32'(cur.busy));
        check_val("done",        32'(done),        32'(cur.done));
        check_val("err",         32'(err),         32'(cur.err));
    endtask

    // Reference: an accepted request becomes the full list of output cycles.
    task automatic model_edge();
        exp_t nxt;
        exp_t e;
        int   frames;
        int   l;
        nxt = '0;
        if (cur.busy && abort) begin
            q.delete();
        end else if (!cur.busy && start && !abort) begin
            l = int'(len);
            if (l >= 1 && l <= int'(MAX_LEN)) begin
                frames = (rep == 0) ? 1 : int'(rep);
                for (int f = 0; f < frames; f++) begin
                    for (int i = l - 1; i >= 0; i--) begin
                        e = '0;
                        e.x = pattern[i[3:0]];
                        e.v = 1'b1;
                        e.fs = (i == l - 1);
                        e.busy = 1'b1;
                        q.push_back(e);
                    end
                    if (f < frames - 1) begin
                        for (int g = 0; g < int'(gap); g++) begin
                            e = '0;
                            e.v = 1'b1;
                            e.busy = 1'b1;
                            q.push_back(e);
                        end
                    end
                end
                e = '0;
                e.done = 1'b1;
                q.push_back(e);
                nxt = q.pop_front();
            end else begin
                nxt.err = 1'b1;
            end
        end else if (q.size() > 0) begin
            nxt = q.pop_front();
        end
        cur = nxt;
    endtask

    task automatic begin_capture();
        xs = '0; xs_n = 0; cyc = 0; fs_mask = '0; z_mask = '0; z_cnt = 0;
        det_h = '0; det_n = 0; done_cyc = 0;
    endtask

    // One clock: drive inputs mid-cycle, update model at the edge, sample after it.
    task automatic step(input logic st, input logic ab);
        @(negedge clk);
        start = st;
        abort = ab;
        @(posedge clk);
        model_edge();
        #1;
        check_outs();
        cyc++;
        if (frame_start && cyc <= 32) fs_mask[cyc-1] = 1'b1;
        if (done && done_cyc == 0) done_cyc = cyc;
        if (x_valid) begin
            xs = {xs[30:0], x};
            xs_n++;
            det_h = {det_h[2:0], x};
            det_n++;
            if (det_n >= 4 && det_h == 4'b1011) begin
                z_cnt++;
                if (cyc <= 32) z_mask[cyc-1] = 1'b1;
                det_n = 0;
            end
        end
    endtask

    task automatic run_until_done(input int max_cyc);
        int n;
        n = 0;
        while (!done && n < max_cyc) begin
            step(1'b0, 1'b0);
            n++;
        end
        check_val("done_seen", 32'(done), 32'd1);
    endtask

    task automatic setup(input logic [15:0] p, input logic [4:0] l, input logic [7:0] r, input logic [3:0] g);
        pattern = p; len = l; rep = r; gap = g;
    endtask

    initial begin
        reset = 1'b1; start = 1'b0; abort = 1'b0;
        pattern = '0; len = '0; rep = '0; gap = '0;
        cur = '0;
        #1;
        check_outs();
        repeat (2) @(posedge clk);
        @(negedge clk);
        reset = 1'b0;

        // Single 4-bit frame 1011.
        setup(16'h000B, 5'd4, 8'd1, 4'd0);
        begin_capture();
        step(1'b1, 1'b0);
        run_until_done(20);
        check_val("t1_stream", xs, 32'hB);
        check_val("t1_nbits", 32'(xs_n), 32'd4);
        check_val("t1_fs_pos", fs_mask, 32'h1);
        check_val("t1_done_cyc", 32'(done_cyc), 32'd5);

        // Two frames with a 2-bit gap; start issued in the done cycle.
        setup(16'h000B, 5'd4, 8'd2, 4'd2);
        begin_capture();
        step(1'b1, 1'b0);
        check_val("done_cycle_start_fs", 32'(frame_start), 32'd1);
        run_until_done(40);
        check_val("t2_stream", xs, 32'h2CB);
        check_val("t2_nbits", 32'(xs_n), 32'd10);
        check_val("t2_fs_pos", fs_mask, 32'h41);
        check_val("t2_done_cyc", 32'(done_cyc), 32'd11);

        // Loopback into a non-overlapping 1011 detector, three frames back-to-back.
        setup(16'h000B, 5'd4, 8'd3, 4'd0);
        step(1'b0, 1'b0);
        begin_capture();
        step(1'b1, 1'b0);
        run_until_done(40);
        check_val("loop_z_cnt", 32'(z_cnt), 32'd3);
        check_val("loop_z_pos", z_mask, 32'h888);
        check_val("loop_fs_pos", fs_mask, 32'h111);

        // Illegal lengths raise err and stay idle.
        setup(16'h00FF, 5'd0, 8'd1, 4'd0);
        step(1'b1, 1'b0);
        check_val("len0_err", 32'(err), 32'd1);
        step(1'b0, 1'b0);
        setup(16'h00FF, 5'd17, 8'd1, 4'd0);
        step(1'b1, 1'b0);
        check_val("len17_err", 32'(err), 32'd1);
        check_val("len17_busy", 32'(busy), 32'd0);
        step(1'b0, 1'b0);

        // Abort on the 2nd bit of the 2nd frame, then a normal transfer.
        setup(16'h000B, 5'd4, 8'd3, 4'd1);
        begin_capture();
        step(1'b1, 1'b0);
        for (int i = 0; i < 6; i++) step(1'b0, 1'b0);
        setup(16'h0000, 5'd2, 8'd9, 4'd7);
        step(1'b0, 1'b1);
        check_val("abort_busy", 32'(busy), 32'd0);
        check_val("abort_valid", 32'(x_valid), 32'd0);
        for (int i = 0; i < 4; i++) step(1'b0, 1'b0);
        check_val("abort_no_done", 32'(done_cyc), 32'd0);
        setup(16'h0005, 5'd3, 8'd1, 4'd0);
        begin_capture();
        step(1'b1, 1'b0);
        run_until_done(20);
        check_val("post_abort_stream", xs, 32'h5);

        // Start while busy is ignored; changing inputs mid-transfer has no effect.
        setup(16'h00A5, 5'd8, 8'd1, 4'd0);
        begin_capture();
        step(1'b1, 1'b0);
        setup(16'hFFFF, 5'd2, 8'd5, 4'd3);
        step(1'b1, 1'b0);
        run_until_done(40);
        check_val("busy_start_stream", xs, 32'hA5);

        // Reset asserted in the middle of a gap.
        setup(16'h0007, 5'd3, 8'd2, 4'd3);
        step(1'b1, 1'b0);
        for (int i = 0; i < 4; i++) step(1'b0, 1'b0);
        #2;
        reset = 1'b1;
        q.delete();
        cur = '0;
        #1;
        check_outs();
        @(posedge clk);
        @(negedge clk);
        reset = 1'b0;
        step(1'b0, 1'b0);

        // Random traffic with live-changing inputs and occasional aborts.
        for (int n = 0; n < 2500; n++) begin
            pattern = 16'($urandom);
            len = ($urandom_range(0, 9) == 0) ? 5'($urandom_range(0, 31)) : 5'($urandom_range(1, 16));
            rep = 8'($urandom_range(0, 3));
            gap = 4'($urandom_range(0, 3));
            step(($urandom_range(0, 3) == 0), (cur.busy && ($urandom_range(0, 29) == 0)));
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
